// File: rtl/mips_pkg.sv
// Shared MIPS fetch definitions: opcode constants, fetch FSM encoding and reset vector.
package mips_pkg;

  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] HALT_OP = 6'b111111;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2,
    StHalt  = 2'd3
  } fetch_state_e;

  function automatic logic is_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: decoded fields and control in, PC and status out.
interface pc_fetch_unit_if;

  logic        stall;
  logic        br_taken;
  logic        jr_en;
  logic [31:0] jr_target;
  logic [5:0]  op;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        addr_fault;

  modport master (
    input  stall, br_taken, jr_en, jr_target, op, offset, instr_index,
    output pc, pc_plus4, fetch_valid, halted, addr_fault
  );

  modport slave (
    output stall, br_taken, jr_en, jr_target, op, offset, instr_index,
    input  pc, pc_plus4, fetch_valid, halted, addr_fault
  );

endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC selection: jr > J/JAL > taken branch > pc+4.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [5:0]  op,
  input  logic [15:0] offset,
  input  logic [25:0] instr_index,
  input  logic        br_taken,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc,
  output logic        redirect
);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        jump;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_tgt   = pc_plus4 + {{14{offset[15]}}, offset, 2'b00};
    j_tgt    = {pc_plus4[31:28], instr_index, 2'b00};
    jump     = is_jump(op);
    redirect = jr_en | jump | br_taken;
    if (jr_en) begin
      npc = jr_target;
    end else if (jump) begin
      npc = j_tgt;
    end else if (br_taken) begin
      npc = br_tgt;
    end else begin
      npc = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch FSM (BOOT/RUN/STALL/HALT) with address range checking.
// Define DELAY_SLOT_EN to enable the MIPS branch delay slot.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_VECTOR,
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [5:0]  HALT_OP    = mips_pkg::HALT_OP
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_unit_if.master bus
);

  import mips_pkg::*;

  localparam logic [32:0] ADDR_LIMIT = 33'(IMEM_WORDS) << 2;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic        redirect;
  logic [31:0] load_pc;
  logic        load_seq;
  logic        load_bad;

`ifdef DELAY_SLOT_EN
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_v_q, pend_v_d;
`endif

  npc_calc u_npc_calc (
    .pc          (pc_q),
    .op          (bus.op),
    .offset      (bus.offset),
    .instr_index (bus.instr_index),
    .br_taken    (bus.br_taken),
    .jr_en       (bus.jr_en),
    .jr_target   (bus.jr_target),
    .pc_plus4    (pc_plus4),
    .npc         (npc),
    .redirect    (redirect)
  );

  // Value the PC would take on a non-stalled RUN edge.
  always_comb begin
    load_pc  = npc;
    load_seq = !redirect;
`ifdef DELAY_SLOT_EN
    if (pend_v_q) begin
      load_pc  = pend_tgt_q;
      load_seq = 1'b0;
    end else if (redirect) begin
      load_pc  = pc_plus4;
      load_seq = 1'b1;
    end
`endif
    // A sequential step from the top word wraps to 0, which would otherwise look legal.
    load_bad = ({1'b0, load_pc} >= ADDR_LIMIT) || (load_pc[1:0] != 2'b00) ||
               (load_seq && (pc_q[31:2] == 30'h3FFF_FFFF));
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
`ifdef DELAY_SLOT_EN
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
`endif
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (bus.stall) begin
          state_d = StStall;
        end else if (bus.op == HALT_OP) begin
          state_d = StHalt;
`ifdef DELAY_SLOT_EN
          pend_v_d = 1'b0;
`endif
        end else if (load_bad) begin
          state_d = StHalt;
          fault_d = 1'b1;
`ifdef DELAY_SLOT_EN
          pend_v_d = 1'b0;
`endif
        end else begin
          pc_d = load_pc;
`ifdef DELAY_SLOT_EN
          // Redirects decoded in the delay slot are ignored.
          if (pend_v_q) begin
            pend_v_d = 1'b0;
          end else if (redirect) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = npc;
          end
`endif
        end
      end
      StStall: begin
        if (!bus.stall) state_d = StRun;
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

`ifdef DELAY_SLOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q   <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
`endif

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = (state_q == StRun);
  assign bus.halted      = (state_q == StHalt);
  assign bus.addr_fault  = fault_q;

endmodule
